// File: rtl/light_cmd_scheduler_pkg.sv
// Shared definitions for the lamp command scheduler slice.
//   - state_t  : scheduler FSM encoding (IDLE / ISSUE / WAIT)
//   - CMD_OFF / CMD_ON : lamp command values
//   - DEF_AUTO_OFF_CYC / DEF_DONE_TO_CYC : default timer settings
package light_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } state_t;

  localparam logic CMD_OFF = 1'b0;
  localparam logic CMD_ON  = 1'b1;

  localparam int DEF_AUTO_OFF_CYC = 1000;
  localparam int DEF_DONE_TO_CYC  = 64;

endpackage

// File: rtl/light_cmd_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : NREQ request vector
//   ptr   : index with highest priority this round
//   grant : one-hot grant, first set request found from ptr upward (wrapping)
//   any   : at least one request is set
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic            any
);

  logic found_s;

  // Walk the requests starting at ptr and grant the first one seen.
  always_comb begin
    grant   = {NREQ{1'b0}};
    found_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = (int'(ptr) + i) % NREQ;
      if (!found_s && req[idx]) begin
        grant[idx] = 1'b1;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any = found_s;

endmodule

// File: rtl/light_cmd_scheduler.sv
// Lamp command scheduler: arbitrates on/off requests from several sources
// onto the single command port of the lamp FSM, one command at a time.
//   clk, reset          : clock, asynchronous active-high reset
//   req_valid/req_on    : per-requester request and requested value
//   req_ack             : one-hot, one-cycle acknowledge
//   cmd_valid/cmd_on    : command to lamp FSM, held until cmd_ready
//   cmd_ready/cmd_done  : lamp FSM accept and completion pulse
//   lamp_state          : committed lamp state
//   busy                : FSM not idle
//   timeout_err         : sticky, a command was abandoned (no cmd_done)
module light_cmd_scheduler
  import light_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int TW           = 16,
  parameter int AUTO_OFF_CYC = DEF_AUTO_OFF_CYC,
  parameter int DONE_TO_CYC  = DEF_DONE_TO_CYC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ-1:0] req_on,
  output logic [NREQ-1:0] req_ack,
  output logic            cmd_valid,
  output logic            cmd_on,
  input  logic            cmd_ready,
  input  logic            cmd_done,
  output logic            lamp_state,
  output logic            busy,
  output logic            timeout_err
);

  localparam int            PW          = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] PTR_LAST    = PW'(NREQ - 1);
  localparam logic [TW-1:0] AUTO_RELOAD = TW'(AUTO_OFF_CYC);
  localparam logic [TW-1:0] WD_LAST     = TW'(DONE_TO_CYC - 1);
  localparam logic          AUTO_EN     = (AUTO_OFF_CYC != 0);

  state_t          state_r, state_s;
  logic [PW-1:0]   rr_ptr_r, rr_ptr_s;
  logic [TW-1:0]   auto_cnt_r, auto_cnt_s;
  logic            auto_pend_r, auto_pend_s;
  logic [TW-1:0]   wdog_r, wdog_s;
  logic            lamp_s, cmd_valid_s, cmd_on_s, timeout_s;
  logic [NREQ-1:0] req_ack_s;
  logic [NREQ-1:0] req_eff_s, grant_s;
  logic            any_s;
  logic [PW-1:0]   win_idx_s, ptr_next_s;
  logic            win_on_s;

  // A requester still shows valid during its ack cycle; mask it so it is not granted twice.
  assign req_eff_s = req_valid & ~req_ack;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req   (req_eff_s),
    .ptr   (rr_ptr_r),
    .grant (grant_s),
    .any   (any_s)
  );

  // Encode the one-hot grant into the winner index and its requested value.
  always_comb begin
    win_idx_s = {PW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      win_idx_s = win_idx_s | (grant_s[i] ? PW'(i) : {PW{1'b0}});
    end
    win_on_s   = req_on[win_idx_s];
    ptr_next_s = (win_idx_s == PTR_LAST) ? {PW{1'b0}} : (win_idx_s + PW'(1));
  end

  // Next-state, command, counter and acknowledge logic.
  always_comb begin
    state_s     = state_r;
    rr_ptr_s    = rr_ptr_r;
    auto_cnt_s  = auto_cnt_r;
    auto_pend_s = auto_pend_r;
    wdog_s      = wdog_r;
    lamp_s      = lamp_state;
    cmd_valid_s = cmd_valid;
    cmd_on_s    = cmd_on;
    timeout_s   = timeout_err;
    req_ack_s   = {NREQ{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (auto_pend_r) begin
          // Internal off command; no requester is acknowledged.
          state_s     = ST_ISSUE;
          cmd_valid_s = 1'b1;
          cmd_on_s    = CMD_OFF;
          auto_pend_s = 1'b0;
        end else if (any_s) begin
          req_ack_s = grant_s;
          rr_ptr_s  = ptr_next_s;
          if (win_on_s == lamp_state) begin
            // Redundant request counts as activity only.
            auto_cnt_s = AUTO_RELOAD;
          end else begin
            state_s     = ST_ISSUE;
            cmd_valid_s = 1'b1;
            cmd_on_s    = win_on_s;
          end
        end else if (AUTO_EN && (lamp_state == CMD_ON)) begin
          // Pending is raised on the step that reaches zero and taken next cycle.
          if (auto_cnt_r <= TW'(1)) begin
            auto_cnt_s  = {TW{1'b0}};
            auto_pend_s = 1'b1;
          end else begin
            auto_cnt_s = auto_cnt_r - TW'(1);
          end
        end else begin
          auto_cnt_s = auto_cnt_r;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          state_s     = ST_WAIT;
          cmd_valid_s = 1'b0;
          wdog_s      = {TW{1'b0}};
        end else begin
          cmd_valid_s = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cmd_done) begin
          lamp_s     = cmd_on;
          auto_cnt_s = AUTO_RELOAD;
          state_s    = ST_IDLE;
        end else if (wdog_r == WD_LAST) begin
          timeout_s = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          wdog_s = wdog_r + TW'(1);
        end
      end
      default: begin
        state_s     = ST_IDLE;
        cmd_valid_s = 1'b0;
      end
    endcase
    // A dark lamp never has an auto-off outstanding.
    if (lamp_s == CMD_OFF) begin
      auto_cnt_s  = AUTO_RELOAD;
      auto_pend_s = 1'b0;
    end else begin
      auto_pend_s = auto_pend_s;
    end
  end

  // State and registered outputs with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= {PW{1'b0}};
      auto_cnt_r  <= AUTO_RELOAD;
      auto_pend_r <= 1'b0;
      wdog_r      <= {TW{1'b0}};
      lamp_state  <= CMD_OFF;
      cmd_valid   <= 1'b0;
      cmd_on      <= CMD_OFF;
      req_ack     <= {NREQ{1'b0}};
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_r     <= state_s;
      rr_ptr_r    <= rr_ptr_s;
      auto_cnt_r  <= auto_cnt_s;
      auto_pend_r <= auto_pend_s;
      wdog_r      <= wdog_s;
      lamp_state  <= lamp_s;
      cmd_valid   <= cmd_valid_s;
      cmd_on      <= cmd_on_s;
      req_ack     <= req_ack_s;
      busy        <= (state_s != ST_IDLE);
      timeout_err <= timeout_s;
    end
  end

endmodule

// File: tb/tb_light_cmd_scheduler.sv
// Scoreboard bench for light_cmd_scheduler: expected acks and commands are
// queued by the stimulus, a negedge monitor pops and compares them.
module tb_light_cmd_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_valid, req_on, req_ack;
  logic       cmd_valid, cmd_on, cmd_ready, cmd_done;
  logic       lamp_state, busy, timeout_err;

  int checks = 0;
  int errors = 0;
  int exp_ack_q[$];
  int exp_cmd_q[$];
  logic cv_prev = 1'b0;

  always #5 clk = ~clk;

  light_cmd_scheduler #(
    .NREQ(4), .TW(16), .AUTO_OFF_CYC(10), .DONE_TO_CYC(8)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_on(req_on), .req_ack(req_ack),
    .cmd_valid(cmd_valid), .cmd_on(cmd_on),
    .cmd_ready(cmd_ready), .cmd_done(cmd_done),
    .lamp_state(lamp_state), .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance one clock; a requester drops its request once acknowledged.
  task automatic tick();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~req_ack;
  endtask

  // Bounded wait for the next command to appear.
  task automatic wait_cmd(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!cmd_valid && n < 20);
    chk(name, cmd_valid, 1'b1);
  endtask

  // Monitor: compare every ack and every rising cmd_valid with the queues.
  always @(negedge clk) begin
    if (reset) begin
      cv_prev = 1'b0;
    end else begin
      if (req_ack != 4'b0000) begin
        if (exp_ack_q.size() == 0) begin
          chk("unexpected_ack", req_ack, 4'b0000);
        end else begin
          logic [3:0] e;
          e = 4'b0001 << exp_ack_q.pop_front();
          chk("ack_order", req_ack, e);
        end
      end
      if (cmd_valid && !cv_prev) begin
        if (exp_cmd_q.size() == 0) begin
          chk("unexpected_cmd", cmd_valid, 1'b0);
        end else begin
          chk("cmd_value", cmd_on, exp_cmd_q.pop_front());
        end
      end
      cv_prev = cmd_valid;
    end
  end

  initial begin
    logic flag;
    reset = 1'b1; req_valid = 4'b0000; req_on = 4'b0000;
    cmd_ready = 1'b0; cmd_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_lamp", lamp_state, 1'b0);
    chk("rst_timeout", timeout_err, 1'b0);
    chk("rst_ack", req_ack, 4'b0000);
    reset = 1'b0;

    // Single request: ack and cmd one cycle later, done sets lamp on.
    req_valid = 4'b0001; req_on = 4'b0001;
    exp_ack_q.push_back(0); exp_cmd_q.push_back(1);
    tick();
    chk("t1_ack", req_ack, 4'b0001);
    chk("t1_cmd_valid", cmd_valid, 1'b1);
    chk("t1_cmd_on", cmd_on, 1'b1);
    chk("t1_busy", busy, 1'b1);
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    chk("t1_done_ignored", cmd_valid, 1'b1);
    chk("t1_ack_one_cycle", req_ack, 4'b0000);
    chk("t1_lamp_still_off", lamp_state, 1'b0);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("t1_cmd_dropped", cmd_valid, 1'b0);
    chk("t1_busy_wait", busy, 1'b1);
    tick(); tick();
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    chk("t1_lamp_on", lamp_state, 1'b1);
    chk("t1_idle", busy, 1'b0);

    // Redundant on-request: acked, no command, counter reloaded.
    req_valid = 4'b0010; req_on = 4'b0010;
    exp_ack_q.push_back(1);
    tick();
    chk("t3_ack", req_ack, 4'b0010);
    chk("t3_no_cmd", cmd_valid, 1'b0);
    chk("t3_idle", busy, 1'b0);

    // Auto-off: 10 quiet cycles, then internal off command on the 11th.
    exp_cmd_q.push_back(0);
    flag = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cmd_valid) flag = 1'b1;
    end
    chk("t4_no_early_off", flag, 1'b0);
    tick();
    chk("t4_off_valid", cmd_valid, 1'b1);
    chk("t4_off_value", cmd_on, 1'b0);
    chk("t4_no_ack", req_ack, 4'b0000);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    chk("t4_lamp_off", lamp_state, 1'b0);

    // Watchdog: cmd_done withheld, 8 WAIT cycles then abandon.
    req_valid = 4'b0100; req_on = 4'b0100;
    exp_ack_q.push_back(2); exp_cmd_q.push_back(1);
    tick();
    chk("t5_issue", busy, 1'b1);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (!busy) flag = 1'b1;
    end
    chk("t5_wait_held", flag, 1'b0);
    tick();
    chk("t5_back_idle", busy, 1'b0);
    chk("t5_timeout", timeout_err, 1'b1);
    chk("t5_lamp_kept", lamp_state, 1'b0);
    tick();
    chk("t5_sticky", timeout_err, 1'b1);

    // Reset mid-WAIT with the lamp on.
    req_valid = 4'b1000; req_on = 4'b1000;
    exp_ack_q.push_back(3); exp_cmd_q.push_back(1);
    tick();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    chk("t6_lamp_on", lamp_state, 1'b1);
    req_valid = 4'b0001; req_on = 4'b0000;
    exp_ack_q.push_back(0); exp_cmd_q.push_back(0);
    tick();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    tick();
    #3 reset = 1'b1;
    #1;
    chk("t6_cmd_valid", cmd_valid, 1'b0);
    chk("t6_lamp", lamp_state, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_timeout", timeout_err, 1'b0);
    chk("t6_ack", req_ack, 4'b0000);
    @(negedge clk);
    reset = 1'b0;

    // Round robin from rr_ptr=0 with all requesters pending.
    req_valid = 4'b1111; req_on = 4'b0101;
    exp_ack_q.push_back(0); exp_ack_q.push_back(1); exp_ack_q.push_back(2);
    exp_ack_q.push_back(3); exp_ack_q.push_back(0);
    exp_cmd_q.push_back(1); exp_cmd_q.push_back(0); exp_cmd_q.push_back(1);
    exp_cmd_q.push_back(0); exp_cmd_q.push_back(1);
    for (int k = 0; k < 5; k++) begin
      wait_cmd("rr_cmd_seen");
      if (k == 0) begin
        req_valid[0] = 1'b1;
        req_on[0]    = 1'b1;
      end
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      cmd_done = 1'b1;
      tick();
      cmd_done = 1'b0;
    end
    chk("rr_lamp_on", lamp_state, 1'b1);
    tick(); tick();
    chk("sb_ack_drained", exp_ack_q.size(), 0);
    chk("sb_cmd_drained", exp_cmd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/light_cmd_scheduler.md
Name: light_cmd_scheduler

Overview:
- Arbitrates lamp on/off requests from several room sources (keypad, remote, occupancy sensor, schedule) onto the single command port of the lamp control FSM.
- Serialises commands: one outstanding at a time, with a valid/ready issue handshake and a done-completion handshake.
- Tracks the committed lamp state and generates an idle auto-off.
- Sits between the input-decoding blocks and the lamp controller.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TW, 16, width of the auto-off and watchdog counters.
- AUTO_OFF_CYC, 1000, idle cycles with the lamp on before an internal off command is issued. 0 disables auto-off.
- DONE_TO_CYC, 64, maximum cycles to wait for cmd_done before the command is abandoned.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request. Held high until acknowledged.
- req_on  in  NREQ  per-requester command: 1 = on, 0 = off. Stable while req_valid is high.
- req_ack  out  NREQ  one-hot, one-cycle acknowledge.
- cmd_valid  out  1  command to the lamp FSM is valid.
- cmd_on  out  1  command value.
- cmd_ready  in  1  lamp FSM accepts the command.
- cmd_done  in  1  lamp FSM has completed the command (one-cycle pulse).
- lamp_state  out  1  committed lamp state.
- busy  out  1  state is not IDLE.
- timeout_err  out  1  sticky; set when a command is abandoned.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, lamp_state=0, cmd_valid=0, cmd_on=0, req_ack=0, busy=0, timeout_err=0, auto-off counter=AUTO_OFF_CYC, watchdog=0.
- States: IDLE, ISSUE, WAIT.
- IDLE, winner selection:
  - An auto_off_pending request beats all external requests.
  - Otherwise the winner is round-robin: search from rr_ptr upward over req_valid, wrapping.
  - On the edge: latch winner and value; rr_ptr <= (winner+1) mod NREQ; req_ack[winner]=1 in the next cycle only.
- IDLE, redundant request (req_on equals lamp_state):
  - No command is issued and the state stays IDLE.
  - req_ack pulses next cycle and rr_ptr advances.
  - If lamp_state=1, the auto-off counter reloads.
- IDLE, non-redundant request: go to ISSUE. cmd_valid=1 and cmd_on=latched value, both registered and held stable until cmd_ready.
- ISSUE: on cmd_valid & cmd_ready, go to WAIT, deassert cmd_valid and clear the watchdog.
- WAIT:
  - On cmd_done: lamp_state <= cmd_on; the auto-off counter reloads; go to IDLE.
  - If the watchdog reaches DONE_TO_CYC-1 without cmd_done: timeout_err <= 1, lamp_state is unchanged, go to IDLE.
  - cmd_done outside WAIT is ignored.
- Auto-off counter:
  - Decrements only in IDLE with lamp_state=1 and no accepted request that cycle.
  - At 0 it sets auto_off_pending, which is taken next IDLE arbitration as an off command with no req_ack.
  - Frozen in ISSUE and WAIT.
  - Cleared (pending=0, counter reloaded) whenever lamp_state becomes 0.
- Latency: request to req_ack is 1 cycle. Request to cmd_valid is 1 cycle. Only one request is accepted per arbitration; losers stay pending.
- Simultaneous events:
  - Auto-off expiry and an external on-request in the same cycle: the on-request is treated as activity. Counter reloads, no auto-off, and the request is acked as redundant.
  - req_valid dropping before ack: the request is treated as withdrawn and never granted. Only sampled valid requests win.
- Reset mid-operation (ISSUE/WAIT): everything returns to reset values at once. cmd_valid drops asynchronously and no ack is issued.
- busy = (state != IDLE).

Decomposition:
- Shared package light_pkg holds:
  - state encoding (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10);
  - constants CMD_OFF=0 and CMD_ON=1;
  - default AUTO_OFF_CYC and DONE_TO_CYC.
- One sub-module, rr_arbiter: NREQ-wide round-robin, inputs req and ptr, outputs one-hot grant and any.
- Counters and the FSM stay in light_cmd_scheduler.

Test Plan:
- Single request: reset, then req_valid=4'b0001 with req_on=1. Expect req_ack=0001 the next cycle, cmd_valid=1 with cmd_on=1 the next cycle, and cmd_valid low after cmd_ready. cmd_done 3 cycles later gives lamp_state=1 and busy=0.
- Round-robin fairness: req_valid=1111 held with alternating on/off values. Expect ack order 0,1,2,3,0.
- Redundant request: with lamp_state=1, req1 on=1 is acked in 1 cycle, cmd_valid never rises, and the auto-off counter reloads.
- Auto-off: AUTO_OFF_CYC=10, lamp on, no requests. Expect cmd_valid with cmd_on=0 after 11 IDLE cycles and no req_ack; after cmd_done, lamp_state=0.
- Watchdog: DONE_TO_CYC=8 and cmd_done withheld. Expect return to IDLE after 8 WAIT cycles, timeout_err=1 (sticky), lamp_state unchanged.
- Reset mid-WAIT: assert reset asynchronously. Expect cmd_valid=0, lamp_state=0, rr_ptr=0; the first request after release is granted normally.
